// File: rtl/axi_wr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// axi_wr_seq_ctrl
// Write-path sequencer for the AXI-to-APB bridge. It asks the AXI slave write
// reader for a burst, waits until every beat is in the beat FIFO, then replays
// the beats one at a time as APB write transfers. It generates the per-beat
// addresses for FIXED/INCR/WRAP bursts, accumulates PSLVERR into a sticky
// write response, and hands that response back to the reader for the B channel.
//
// Optional feature: define BRIDGE_WDT_EN to add an APB completion watchdog.
// When it is enabled, a beat that sees no apb_done within WDT_CYCLES WAIT
// cycles completes as an error beat.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   enable           allows a new burst to start from IDLE
//   rd_cmd[1:0]      reader command: 0 NONE, 1 GET_ADDR_DATA, 2 GET_RESP
//   rd_info[1:0]     reader status: 0 IDLE, 1 BUSY, 2 SWITCH
//   ai_addr/len/size/burst  burst description from the reader (sampled on SWITCH)
//   fifo_empty       beat FIFO empty
//   fifo_read        single-cycle pop of the FIFO head
//   apb_req          one-cycle start of an APB write of the FIFO head
//   apb_addr         address of the current beat
//   apb_done/apb_err APB beat completion pulse and its PSLVERR
//   wr_resp[1:0]     accumulated response: 00 OKAY, 10 SLVERR
//   busy             high in every state except IDLE
//
// Reader handshake: rd_cmd is a level. The sequencer holds a command until
// rd_info reports BUSY, which acknowledges it, and only then drops or changes
// the command. SWITCH, seen while collecting, means that all beats of the
// burst are in the FIFO and the ai_* fields are valid in that cycle.
// -----------------------------------------------------------------------------
module axi_wr_seq_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int WDT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic [1:0]            rd_cmd,
  input  logic [1:0]            rd_info,
  input  logic [ADDR_WIDTH-1:0] ai_addr,
  input  logic [3:0]            ai_len,
  input  logic [2:0]            ai_size,
  input  logic [1:0]            ai_burst,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  output logic                  apb_req,
  output logic [ADDR_WIDTH-1:0] apb_addr,
  input  logic                  apb_done,
  input  logic                  apb_err,
  output logic [1:0]            wr_resp,
  output logic                  busy
);

  localparam logic [1:0] CMD_NONE     = 2'd0;
  localparam logic [1:0] CMD_GET_DATA = 2'd1;
  localparam logic [1:0] CMD_GET_RESP = 2'd2;

  localparam logic [1:0] INFO_IDLE    = 2'd0;
  localparam logic [1:0] INFO_BUSY    = 2'd1;
  localparam logic [1:0] INFO_SWITCH  = 2'd2;

  localparam logic [1:0] BURST_FIXED  = 2'd0;
  localparam logic [1:0] BURST_WRAP   = 2'd2;
  localparam logic [1:0] BURST_RSVD   = 2'd3;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_COLLECT = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT    = 3'd4,
    S_DRAIN   = 3'd5,
    S_RESP    = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [3:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [3:0]            beat_cnt;

  logic                  wdt_expired;
  logic                  beat_done;
  logic                  beat_err;
  logic                  last_beat;
  logic                  latch_burst;

  // ---------------------------------------------------------------------------
  // Next beat address
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  wrap_len_ok;

  always_comb begin
    step        = ADDR_WIDTH'(1) << size_q;
    incr_addr   = cur_addr + step;
    // The wrap boundary is the total burst size; the low bits wrap inside it.
    wrap_mask   = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    wrap_len_ok = (len_q == 4'd1) || (len_q == 4'd3) || (len_q == 4'd7) || (len_q == 4'd15);
    next_addr   = incr_addr;
    if (burst_q == BURST_FIXED) begin
      next_addr = cur_addr;
    end else if ((burst_q == BURST_WRAP) && wrap_len_ok) begin
      next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end
  end

  // ---------------------------------------------------------------------------
  // APB completion watchdog
  // ---------------------------------------------------------------------------
`ifdef BRIDGE_WDT_EN
  localparam int WDT_W = (WDT_CYCLES < 2) ? 1 : $clog2(WDT_CYCLES);
  logic [WDT_W-1:0] wdt_cnt;

  // Counts WAIT cycles of the current beat; zero in the first WAIT cycle, so
  // the timeout fires in the WDT_CYCLES-th WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wdt_cnt <= '0;
    end else if ((state == S_WAIT) && !wdt_expired) begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end

  assign wdt_expired = (state == S_WAIT) && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
`else
  logic unused_wdt_cfg;
  assign unused_wdt_cfg = (WDT_CYCLES != 0);
  assign wdt_expired    = 1'b0;
`endif

  // A real apb_done wins over a timeout in the same cycle.
  assign beat_done   = (state == S_WAIT) && (apb_done || wdt_expired);
  assign beat_err    = apb_done ? apb_err : 1'b1;
  assign last_beat   = (beat_cnt == len_q);
  assign latch_burst = (state == S_COLLECT) && (rd_info == INFO_SWITCH);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_cmd    = CMD_NONE;
    apb_req   = 1'b0;
    fifo_read = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable && (rd_info == INFO_IDLE)) state_nxt = S_ARM;
      end
      S_ARM: begin
        rd_cmd = CMD_GET_DATA;
        if (rd_info == INFO_BUSY) state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (rd_info == INFO_SWITCH) begin
          state_nxt = (ai_burst == BURST_RSVD) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!fifo_empty) begin
          apb_req   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // The beat being completed is the FIFO head, so the pop is
        // unconditional even if fifo_empty is reported in this cycle.
        if (beat_done) begin
          fifo_read = 1'b1;
          state_nxt = last_beat ? S_RESP : S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (!fifo_empty) begin
          fifo_read = 1'b1;
          if (last_beat) state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rd_cmd = CMD_GET_RESP;
        if (rd_info == INFO_BUSY) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Burst datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_cnt <= '0;
      wr_resp  <= RESP_OKAY;
    end else if (latch_burst) begin
      cur_addr <= ai_addr;
      len_q    <= ai_len;
      size_q   <= ai_size;
      burst_q  <= ai_burst;
      beat_cnt <= '0;
      wr_resp  <= RESP_OKAY;
    end else if (beat_done) begin
      if (beat_err) wr_resp <= RESP_SLVERR;
      if (!last_beat) begin
        beat_cnt <= beat_cnt + 4'd1;
        cur_addr <= next_addr;
      end
    end else if ((state == S_DRAIN) && !fifo_empty) begin
      if (last_beat) begin
        wr_resp <= RESP_SLVERR;
      end else begin
        beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

  assign apb_addr = cur_addr;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_axi_wr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_seq_ctrl
// Bench for axi_wr_seq_ctrl. Models the write reader, the beat FIFO (as
// pushed/popped counts) and the APB writer. Expected beat addresses and
// responses come from a burst-level reference model and are queued at issue
// time; a negedge monitor pops and compares whenever the DUT presents
// apb_req, fifo_read or GET_RESP. Inputs change 1 time unit after posedge,
// and outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_axi_wr_seq_ctrl;
  localparam int AW = 32;
`ifdef BRIDGE_WDT_EN
  localparam int WDT = 8;
`else
  localparam int WDT = 255;
`endif
  localparam int LONG_DLY = (WDT > 12) ? 10 : WDT - 3;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    rd_info = 2'd0;
  logic [AW-1:0] ai_addr = '0;
  logic [3:0]    ai_len = '0;
  logic [2:0]    ai_size = '0;
  logic [1:0]    ai_burst = '0;
  logic          fifo_empty;
  logic          apb_done = 1'b0;
  logic          apb_err = 1'b0;
  logic [1:0]    rd_cmd;
  logic          fifo_read;
  logic          apb_req;
  logic [AW-1:0] apb_addr;
  logic [1:0]    wr_resp;
  logic          busy;

  always #5 clk = ~clk;

  axi_wr_seq_ctrl #(.ADDR_WIDTH(AW), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rd_cmd(rd_cmd), .rd_info(rd_info),
    .ai_addr(ai_addr), .ai_len(ai_len), .ai_size(ai_size), .ai_burst(ai_burst),
    .fifo_empty(fifo_empty), .fifo_read(fifo_read), .apb_req(apb_req),
    .apb_addr(apb_addr), .apb_done(apb_done), .apb_err(apb_err),
    .wr_resp(wr_resp), .busy(busy)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] exp_q[$];
  logic [1:0]    exp_resp_q[$];

  int   pushed = 0, popped = 0;
  bit   hold_empty = 1'b0;
  assign fifo_empty = hold_empty || (popped >= pushed);

  bit          pop_pending = 1'b0, awaiting = 1'b0, req_prev = 1'b0;
  bit          resp_seen = 1'b0, done_enable = 1'b1, done_genuine = 1'b0, stray_req = 1'b0;
  int          beats_seen = 0, pops_seen = 0, wait_cycles = 0, wait_left = 0;
  int          done_delay = 0, drain_left = 0, cur_len = 0, cur_burst = 0;
  logic [15:0] cur_err_mask = '0;
  logic [AW-1:0] issued_addr = '0;
  logic [1:0]    resp_val = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push_model(input logic [AW-1:0] a, input int len, input int size,
                                     input int burst, input logic [15:0] emask);
    longint unsigned au, step, wb, lower, off, x;
    bit any_err;
    au = longint'(a);
    step = 64'd1 << size;
    wb = longint'(len + 1) * step;
    any_err = 1'b0;
    for (int i = 0; i <= len; i++) if (emask[i]) any_err = 1'b1;
    if (burst == 3) begin
      exp_resp_q.push_back(2'b10);
      return;
    end
    for (int i = 0; i <= len; i++) begin
      if (burst == 0) x = au;
      else if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
        off = au % wb;
        lower = au - off;
        x = lower + ((off + longint'(i) * step) % wb);
      end else x = au + longint'(i) * step;
      exp_q.push_back(x[AW-1:0]);
    end
    exp_resp_q.push_back(any_err ? 2'b10 : 2'b00);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit exp_pop;
    if (rst_n) begin
      if (awaiting) wait_cycles++;
      if (apb_req) begin
        check("apb_req_single_cycle", 64'(req_prev), 64'd0);
        check("apb_req_fifo_nonempty", 64'(fifo_empty), 64'd0);
        if (exp_q.size() == 0) check("apb_req_unexpected", 64'(apb_req), 64'd0);
        else check("apb_addr", 64'(apb_addr), 64'(exp_q.pop_front()));
        issued_addr = apb_addr;
        awaiting = 1'b1;
        wait_cycles = 0;
        wait_left = done_delay;
        beats_seen++;
      end
      req_prev = apb_req;

      exp_pop = 1'b0;
      if (apb_done && done_genuine) exp_pop = 1'b1;
      if (drain_left > 0 && !fifo_empty) exp_pop = 1'b1;
`ifdef BRIDGE_WDT_EN
      if (awaiting && !apb_done && wait_cycles == WDT) exp_pop = 1'b1;
`endif
      if (fifo_read || exp_pop) check("fifo_read", 64'(fifo_read), 64'(exp_pop));
      if (apb_done && done_genuine) check("apb_addr_held", 64'(apb_addr), 64'(issued_addr));
      if (exp_pop && awaiting) awaiting = 1'b0;
      if (fifo_read) begin
        pop_pending = 1'b1;
        pops_seen++;
        if (drain_left > 0) drain_left--;
      end

      if (rd_cmd == 2'd2) begin
        if (!resp_seen) begin
          if (exp_resp_q.size() == 0) check("resp_unexpected", 64'(rd_cmd), 64'd0);
          else check("wr_resp", 64'(wr_resp), 64'(exp_resp_q.pop_front()));
          resp_val = wr_resp;
          resp_seen = 1'b1;
        end else check("wr_resp_stable", 64'(wr_resp), 64'(resp_val));
      end else resp_seen = 1'b0;
    end
  end

  // ---------------- FIFO model: apply pops seen in the previous cycle ----------------
  always @(posedge clk) begin
    #1;
    if (pop_pending) begin
      popped++;
      pop_pending = 1'b0;
    end
  end

  // ---------------- APB writer model ----------------
  always @(posedge clk) begin
    #1;
    apb_done = 1'b0;
    apb_err = 1'b0;
    done_genuine = 1'b0;
    if (stray_req) begin
      apb_done = 1'b1;
      apb_err = 1'b1;
      stray_req = 1'b0;
    end else if (awaiting && done_enable) begin
      if (wait_left == 0) begin
        apb_done = 1'b1;
        apb_err = cur_err_mask[beats_seen-1];
        done_genuine = 1'b1;
      end else wait_left--;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cmd(input logic [1:0] c, input int limit, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rd_cmd == c) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic start_burst(input logic [AW-1:0] addr, input int len, input int size,
                             input int burst, input logic [15:0] emask, input int hold,
                             input int dly);
    push_model(addr, len, size, burst, emask);
    cur_err_mask = emask;
    done_delay = dly;
    beats_seen = 0;
    pops_seen = 0;
    cur_len = len;
    cur_burst = burst;
    @(posedge clk); #1;
    ai_addr = addr; ai_len = 4'(len); ai_size = 3'(size); ai_burst = 2'(burst);
    enable = 1'b1;
    rd_info = 2'd0;
    wait_cmd(2'd1, 20, "arm_cmd_timeout");
    @(posedge clk); #1;
    rd_info = 2'd1;
    enable = 1'b0;
    @(posedge clk); #1;
    rd_info = 2'd2;
    pushed += len + 1;
    hold_empty = (hold > 0);
    @(posedge clk); #1;
    rd_info = 2'd0;
    if (burst == 3) drain_left = len + 1;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 hold_empty = 1'b0;
    end
  endtask

  task automatic finish_burst();
    wait_cmd(2'd2, 3000, "resp_cmd_timeout");
    @(posedge clk); #1;
    rd_info = 2'd1;
    @(posedge clk); #1;
    rd_info = 2'd0;
    @(negedge clk);
    check("idle_after_burst", 64'(busy), 64'd0);
    check("pop_count", 64'(pops_seen), 64'(cur_len + 1));
    check("beat_count", 64'(beats_seen), 64'((cur_burst == 3) ? 0 : cur_len + 1));
    check("addr_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_first_req();
    for (int i = 0; i < 50 && beats_seen == 0; i++) @(negedge clk);
    check("first_req_timeout", 64'(beats_seen), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_cmd"}, 64'(rd_cmd), 64'd0);
    check({tag, "_fifo_read"}, 64'(fifo_read), 64'd0);
    check({tag, "_apb_req"}, 64'(apb_req), 64'd0);
    check({tag, "_apb_addr"}, 64'(apb_addr), 64'd0);
    check({tag, "_wr_resp"}, 64'(wr_resp), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Asynchronous reset in the middle of a cycle, then bench models restart.
  task automatic reset_mid(input string tag);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    exp_q.delete();
    exp_resp_q.delete();
    awaiting = 1'b0; req_prev = 1'b0; drain_left = 0; done_enable = 1'b1;
    pushed = 0; popped = 0; pop_pending = 1'b0; hold_empty = 1'b0;
    rd_info = 2'd0; enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: INCR, no errors
    start_burst(32'h1000, 3, 2, 1, 16'h0000, 0, 0);
    finish_burst();
    // 2: WRAP from the middle of the wrap window
    start_burst(32'h2008, 3, 2, 2, 16'h0000, 0, 1);
    finish_burst();
    // 3: FIXED with error on beat 1, sticky past beat 2
    start_burst(32'h3000, 2, 2, 0, 16'h0002, 0, 2);
    finish_burst();
    // 4: reserved burst drains without APB traffic
    start_burst(32'h4000, 1, 2, 3, 16'h0000, 0, 0);
    finish_burst();
    // stray apb_done in IDLE must not pop
    @(negedge clk) stray_req = 1'b1;
    @(negedge clk);
    check("stray_done_no_pop", 64'(fifo_read), 64'd0);
    check("stray_done_idle", 64'(busy), 64'd0);
    // 5: FIFO empty in ISSUE, late apb_done in WAIT
    start_burst(32'h5000, 2, 1, 1, 16'h0000, 5, LONG_DLY);
    finish_burst();
    // 5b: reset while in WAIT
    done_enable = 1'b0;
    start_burst(32'h5100, 1, 2, 1, 16'hFFFF, 0, 0);
    wait_first_req();
    repeat (3) @(posedge clk);
    reset_mid("reset_in_wait");

    // 6: apb_done never arrives
    done_enable = 1'b0;
    start_burst(32'h6000, 0, 2, 1, 16'hFFFF, 0, 0);
`ifdef BRIDGE_WDT_EN
    finish_burst();
    done_enable = 1'b1;
`else
    wait_first_req();
    repeat (300) @(negedge clk);
    check("no_wdt_still_busy", 64'(busy), 64'd1);
    check("no_wdt_no_pop", 64'(pops_seen), 64'd0);
    check("no_wdt_no_resp", 64'(rd_cmd), 64'd0);
    reset_mid("reset_after_hang");
`endif

    // random bursts
    for (int n = 0; n < 25; n++) begin
      logic [AW-1:0] a;
      logic [15:0] m;
      a = $urandom;
      m = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
      start_burst(a, $urandom_range(0, 15), $urandom_range(0, 2), $urandom_range(0, 3), m,
                  $urandom_range(0, 2), $urandom_range(0, 3));
      finish_burst();
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk) stray_req = 1'b1;
        @(negedge clk);
        check("stray_done_no_pop", 64'(fifo_read), 64'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
